cache_mem_arbiter: RTL and testbench

Shares the single off-chip memory port between the I-cache miss path and the D-cache miss/write-back path of the five-stage RISC-V core. D-cache traffic has priority; a starvation guard bounds I-cache wait. One transaction at a time, fully serialized, with a registered request latch so requesters and memory see stable address/data for the whole transfer.

---
 rtl/cache_arb_pkg.sv | 22 ++
 rtl/arb_starve_ctr.sv | 30 +++
 rtl/cache_mem_arbiter.sv | 116 +++++++++++
 tb/tb_cache_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the cache-to-memory arbiter and its clients.
package cache_arb_pkg;

    localparam int unsigned CACHE_ADDR_W = 28;
    localparam int unsigned CACHE_DATA_W = 128;
    localparam int unsigned STARVE_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        GNT_I,
        GNT_D,
        RESP_I,
        RESP_D
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of D grants taken while the I-cache is kept waiting.
module arb_starve_ctr
    import cache_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != LIMIT_V)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign at_limit = (count_q == LIMIT_V);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Serializes I-cache fills and D-cache fills/write-backs onto one memory port,
// D first, with a starvation guard that eventually forces the I-cache through.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = CACHE_ADDR_W,
    parameter int unsigned DATA_W       = CACHE_DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    arb_state_t        state_q, state_d;
    owner_t            grant;
    logic              d_req;
    logic              at_limit;
    logic              starve_inc, starve_clr;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic              req_write_q;
    logic [DATA_W-1:0] rdata_q;

    assign d_req = d_mem_read | d_mem_write;

    always_comb begin
        state_d = state_q;
        grant   = OWN_NONE;
        case (state_q)
            IDLE: begin
                // D wins unless I is pending and has already waited out its budget
                if (d_req && !(i_mem_read && at_limit)) begin
                    grant   = OWN_D;
                    state_d = GNT_D;
                end else if (i_mem_read) begin
                    grant   = OWN_I;
                    state_d = GNT_I;
                end
            end
            GNT_I:   if (mem_ready) state_d = RESP_I;
            GNT_D:   if (mem_ready) state_d = RESP_D;
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign starve_inc = (grant == OWN_D) && i_mem_read;
    assign starve_clr = (grant == OWN_I) || ((state_q == IDLE) && !i_mem_read);

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_write_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            case (grant)
                OWN_I: begin
                    req_addr_q  <= i_mem_addr;
                    req_write_q <= 1'b0;
                end
                OWN_D: begin
                    // read+write together collapse into a single write-back
                    req_addr_q  <= d_mem_addr;
                    req_write_q <= d_mem_write;
                    if (d_mem_write) req_wdata_q <= d_mem_wdata;
                end
                default: ;
            endcase
            if (((state_q == GNT_I) || (state_q == GNT_D)) && mem_ready) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_read    = (state_q == GNT_I) || ((state_q == GNT_D) && !req_write_q);
    assign mem_write   = (state_q == GNT_D) && req_write_q;
    assign mem_addr    = req_addr_q;
    assign mem_wdata   = req_wdata_q;
    assign i_mem_ready = (state_q == RESP_I);
    assign d_mem_ready = (state_q == RESP_D);
    assign i_mem_rdata = rdata_q;
    assign d_mem_rdata = rdata_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench: expected transactions are queued in grant order and checked as memory serves them.
module tb_cache_mem_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_mem_read;
    logic [AW-1:0] i_mem_addr;
    logic [DW-1:0] i_mem_rdata;
    logic          i_mem_ready;
    logic          d_mem_read;
    logic          d_mem_write;
    logic [AW-1:0] d_mem_addr;
    logic [DW-1:0] d_mem_wdata;
    logic [DW-1:0] d_mem_rdata;
    logic          d_mem_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            own_d;
        bit            wr;
        bit            both;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } item_t;

    item_t q[$];

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_read  (i_mem_read),
        .i_mem_addr  (i_mem_addr),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ready (i_mem_ready),
        .d_mem_read  (d_mem_read),
        .d_mem_write (d_mem_write),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata),
        .d_mem_rdata (d_mem_rdata),
        .d_mem_ready (d_mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push(input bit own_d, input bit wr, input bit both, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
        item_t e;
        e.own_d = own_d; e.wr = wr; e.both = both;
        e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        q.push_back(e);
    endtask

    // Each requester presents its oldest outstanding item, or nothing.
    task automatic apply_inputs();
        bit fi = 1'b0;
        bit fd = 1'b0;
        i_mem_read  = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        foreach (q[k]) begin
            if (!q[k].own_d && !fi) begin
                fi = 1'b1;
                i_mem_read = 1'b1;
                i_mem_addr = q[k].addr;
            end
            if (q[k].own_d && !fd) begin
                fd = 1'b1;
                d_mem_read  = !q[k].wr || q[k].both;
                d_mem_write = q[k].wr;
                d_mem_addr  = q[k].addr;
                d_mem_wdata = q[k].wdata;
            end
        end
    endtask

    // Serve the expected head transaction with `lat` strobe cycles; called at a negedge in IDLE.
    task automatic serve(input int lat, input bit scramble);
        item_t e;
        int    w;
        bit    ok;
        e = q.pop_front();
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(mem_read || mem_write) && w < 20);
        chk("grant_latency", DW'(w), DW'(1));
        chk("mem_read", DW'(mem_read), DW'(!e.wr));
        chk("mem_write", DW'(mem_write), DW'(e.wr));
        chk("mem_addr", DW'(mem_addr), DW'(e.addr));
        if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
        chk("busy_gnt", DW'(busy), DW'(1));
        ok = 1'b1;
        for (int k = 1; k < lat; k++) begin
            if (scramble) begin
                if (e.own_d) begin
                    d_mem_addr  = AW'($urandom);
                    d_mem_wdata = rnd128();
                end else begin
                    i_mem_addr = AW'($urandom);
                end
            end
            @(negedge clk);
            if (mem_read !== !e.wr || mem_write !== e.wr || mem_addr !== e.addr ||
                (e.wr && mem_wdata !== e.wdata) || i_mem_ready || d_mem_ready) ok = 1'b0;
        end
        chk("strobe_stable", DW'(ok), DW'(1));
        mem_ready = 1'b1;
        mem_rdata = e.rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = rnd128();
        chk("strobe_drop", DW'({mem_read, mem_write}), DW'(0));
        chk("i_ready", DW'(i_mem_ready), DW'(!e.own_d));
        chk("d_ready", DW'(d_mem_ready), DW'(e.own_d));
        if (e.own_d) chk("d_rdata", d_mem_rdata, e.rdata);
        else         chk("i_rdata", i_mem_rdata, e.rdata);
        apply_inputs();
        @(negedge clk);
        chk("ready_single", DW'({i_mem_ready, d_mem_ready}), DW'(0));
        chk("busy_idle", DW'(busy), DW'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        i_mem_read = 1'b0; i_mem_addr = '0;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_strobes", DW'({mem_read, mem_write, i_mem_ready, d_mem_ready, busy}), DW'(0));
        chk("rst_addr", DW'(mem_addr), DW'(0));
        chk("rst_wdata", mem_wdata, DW'(0));
        chk("rst_rdata", i_mem_rdata | d_mem_rdata, DW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // lone I fill, 3-cycle memory
        push(1'b0, 1'b0, 1'b0, AW'(28'h0000010), '0, {16{8'hA5}});
        apply_inputs();
        serve(3, 1'b0);

        // simultaneous I read and D write: D first, then I
        push(1'b1, 1'b1, 1'b0, AW'(28'h0100200), rnd128(), rnd128());
        push(1'b0, 1'b0, 1'b0, AW'(28'h0000400), '0, rnd128());
        apply_inputs();
        serve(1, 1'b0);
        serve(2, 1'b0);

        // I pending through back-to-back D reads: forced after the 4th D grant
        for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 1'b0, AW'(28'h0200000 + k), '0, rnd128());
        push(1'b0, 1'b0, 1'b0, AW'(28'h0300000), '0, rnd128());
        for (int k = 4; k < 6; k++) push(1'b1, 1'b0, 1'b0, AW'(28'h0200000 + k), '0, rnd128());
        apply_inputs();
        for (int k = 0; k < 7; k++) serve(1, 1'b0);
        chk("starve_cleared", DW'(dut.u_starve.count_q), DW'(0));

        // read and write together: one write transaction
        push(1'b1, 1'b1, 1'b1, AW'(28'h0ABCDEF), rnd128(), rnd128());
        apply_inputs();
        serve(2, 1'b0);

        // requester inputs change mid-transfer; latched values must hold
        push(1'b0, 1'b0, 1'b0, AW'(28'h1234567), '0, rnd128());
        apply_inputs();
        serve(4, 1'b1);
        push(1'b1, 1'b1, 1'b0, AW'(28'h0FEDCBA), rnd128(), rnd128());
        apply_inputs();
        serve(3, 1'b1);

        // stray mem_ready while idle produces nothing
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("stray_ready", DW'({i_mem_ready, d_mem_ready, busy}), DW'(0));

        // reset while in GNT_D abandons the transfer
        d_mem_read = 1'b1;
        d_mem_addr = AW'(28'h5555555);
        @(negedge clk);
        chk("pre_rst_gnt", DW'(mem_read), DW'(1));
        rst_n = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = rnd128();
        d_mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        chk("midrst_strobes", DW'({mem_read, mem_write, i_mem_ready, d_mem_ready, busy}), DW'(0));
        chk("midrst_addr", DW'(mem_addr), DW'(0));
        chk("midrst_rdata", i_mem_rdata | d_mem_rdata, DW'(0));
        @(negedge clk);
        chk("midrst_no_pulse", DW'({i_mem_ready, d_mem_ready, busy}), DW'(0));
        push(1'b1, 1'b0, 1'b0, AW'(28'h0777777), '0, rnd128());
        apply_inputs();
        serve(1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
